wishbone_subordinate_regs: RTL and testbench

- Wishbone classic-cycle subordinate (responder) that terminates single read/write cycles issued by the team's wishbone_manager through the interconnect.
- Exposes a bank of 32-bit control/status registers to the user design and supports byte-lane writes.
- Inserts a programmable number of wait states before ACK.
- Sits on the interconnect side opposite the manager. Out-of-window addresses are never acknowledged; the interconnect handles them.

---
 rtl/wishbone_subordinate_regs.sv | 164 ++++++++++++++++
 tb/tb_wishbone_subordinate_regs.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_subordinate_regs.sv
// Wishbone classic-cycle subordinate exposing NUM_REGS 32-bit registers.
// Single read/write cycles only; byte-lane writes; WAIT_CYCLES wait states
// between request capture and ACK. Addresses outside the register window
// are never acknowledged.
//
// Handshake: a request is presented when CYC_I & STB_I are both high and is
// held by the manager until ACK_O. ACK_O is high for exactly one cycle per
// accepted transfer. Dropping CYC_I or STB_I before ACK abandons the transfer
// with no side effects. DAT_O carries read data only while ACK_O is high.
module wishbone_subordinate_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [31:0]              ADR_I,
    input  logic [31:0]              DAT_I,
    input  logic [3:0]               SEL_I,
    input  logic                     WE_I,
    input  logic                     STB_I,
    input  logic                     CYC_I,
    output logic [31:0]              DAT_O,
    output logic                     ACK_O,
    output logic [32*NUM_REGS-1:0]   REG_O,
    output logic [NUM_REGS-1:0]      REG_WR_O,
    output logic [1:0]               DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [32:0] SPAN = 33'(4 * NUM_REGS);

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  req_idx;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic [31:0] regs [NUM_REGS];

    logic [31:0] offset;
    logic        hit;
    logic [3:0]  idx_in;
    logic [3:0]  c_idx;
    logic        c_we;
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic        go_ack;

    // Address decode: offset comparison avoids overflow near the top of memory.
    always_comb begin
        offset = ADR_I - BASE_ADDR;
        hit    = CYC_I & STB_I & (ADR_I >= BASE_ADDR) &
                 ({1'b0, offset} < SPAN) & (ADR_I[1:0] == 2'b00);
        idx_in = offset[5:2];
    end

    // Fields used at ACK entry: live inputs when jumping straight from IDLE
    // (zero wait states), otherwise the copy latched at request capture.
    always_comb begin
        if (state == ST_IDLE) begin
            c_idx = idx_in;
            c_we  = WE_I;
            c_sel = SEL_I;
            c_dat = DAT_I;
        end else begin
            c_idx = req_idx;
            c_we  = req_we;
            c_sel = req_sel;
            c_dat = req_dat;
        end
    end

    // Selected register word and its byte-lane merge with the write data.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (c_idx == 4'(k)) rd_word = regs[k];
        end
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = c_sel[b] ? c_dat[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    // Transition into ACK: either a hit with no wait states, or the last wait
    // state with the request still asserted.
    always_comb begin
        go_ack = ((state == ST_IDLE) && hit && (WAIT_CYCLES == 0)) ||
                 ((state == ST_WAIT) && (cnt == 4'd1) && CYC_I && STB_I);
    end

    // FSM, request latch, register bank and registered bus outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            req_idx  <= '0;
            req_we   <= 1'b0;
            req_sel  <= '0;
            req_dat  <= '0;
            ACK_O    <= 1'b0;
            DAT_O    <= '0;
            REG_WR_O <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            ACK_O    <= 1'b0;
            DAT_O    <= '0;
            REG_WR_O <= '0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        req_idx <= idx_in;
                        req_we  <= WE_I;
                        req_sel <= SEL_I;
                        req_dat <= DAT_I;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!(CYC_I && STB_I)) begin
                        state <= ST_IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (go_ack) begin
                ACK_O <= 1'b1;
                if (c_we) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (c_idx == 4'(k)) begin
                            regs[k]     <= merged;
                            REG_WR_O[k] <= 1'b1;
                        end
                    end
                end else begin
                    DAT_O <= rd_word;
                end
            end
        end
    end

    // Flattened register view and FSM state for observation.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) REG_O[32*k +: 32] = regs[k];
        DBG_STATE = state;
    end

endmodule

// File: tb/tb_wishbone_subordinate_regs.sv
// Directed bench for wishbone_subordinate_regs. Four instances share clock
// and reset but have private buses: [0] WAIT_CYCLES=1, [1] WAIT_CYCLES=0,
// [2] WAIT_CYCLES=15, [3] WAIT_CYCLES=4. All use the default base and size.
module tb_wishbone_subordinate_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  adr [4];
    logic [31:0]  dat_i [4];
    logic [3:0]   sel [4];
    logic         we [4];
    logic         stb [4];
    logic         cyc [4];
    logic [31:0]  dat_o [4];
    logic         ack [4];
    logic [255:0] reg_o [4];
    logic [7:0]   reg_wr [4];
    logic [1:0]   dbg [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wishbone_subordinate_regs #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_CYCLES(1)) u_w1 (
        .CLK(clk), .nRST(rst_n), .ADR_I(adr[0]), .DAT_I(dat_i[0]), .SEL_I(sel[0]),
        .WE_I(we[0]), .STB_I(stb[0]), .CYC_I(cyc[0]), .DAT_O(dat_o[0]), .ACK_O(ack[0]),
        .REG_O(reg_o[0]), .REG_WR_O(reg_wr[0]), .DBG_STATE(dbg[0]));
    wishbone_subordinate_regs #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_CYCLES(0)) u_w0 (
        .CLK(clk), .nRST(rst_n), .ADR_I(adr[1]), .DAT_I(dat_i[1]), .SEL_I(sel[1]),
        .WE_I(we[1]), .STB_I(stb[1]), .CYC_I(cyc[1]), .DAT_O(dat_o[1]), .ACK_O(ack[1]),
        .REG_O(reg_o[1]), .REG_WR_O(reg_wr[1]), .DBG_STATE(dbg[1]));
    wishbone_subordinate_regs #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_CYCLES(15)) u_w15 (
        .CLK(clk), .nRST(rst_n), .ADR_I(adr[2]), .DAT_I(dat_i[2]), .SEL_I(sel[2]),
        .WE_I(we[2]), .STB_I(stb[2]), .CYC_I(cyc[2]), .DAT_O(dat_o[2]), .ACK_O(ack[2]),
        .REG_O(reg_o[2]), .REG_WR_O(reg_wr[2]), .DBG_STATE(dbg[2]));
    wishbone_subordinate_regs #(.BASE_ADDR(BASE), .NUM_REGS(8), .WAIT_CYCLES(4)) u_w4 (
        .CLK(clk), .nRST(rst_n), .ADR_I(adr[3]), .DAT_I(dat_i[3]), .SEL_I(sel[3]),
        .WE_I(we[3]), .STB_I(stb[3]), .CYC_I(cyc[3]), .DAT_O(dat_o[3]), .ACK_O(ack[3]),
        .REG_O(reg_o[3]), .REG_WR_O(reg_wr[3]), .DBG_STATE(dbg[3]));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        adr[i] = a; dat_i[i] = d; sel[i] = s; we[i] = w; cyc[i] = 1'b1; stb[i] = 1'b1;
    endtask

    task automatic idle_bus(input int i);
        cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
        adr[i] = '0; dat_i[i] = '0; sel[i] = '0;
    endtask

    // One transfer: checks ACK latency, data/strobe in the ACK cycle, the
    // touched register, DAT_O idle before ACK and ACK width of one cycle.
    task automatic xfer(input int i, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int lat,
                        input logic [31:0] exp_dat, input logic [7:0] exp_wr,
                        input int ridx, input logic [31:0] exp_reg, input string tag);
        int  n = 0;
        bit  got = 1'b0;
        bit  dat_leak = 1'b0;
        drive(i, w, a, d, s);
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[i]) got = 1'b1;
            else if (dat_o[i] !== 32'h0) dat_leak = 1'b1;
        end
        check({tag, "_lat"}, 256'(n), 256'(lat));
        check({tag, "_dat"}, 256'(dat_o[i]), 256'(exp_dat));
        check({tag, "_wr"}, 256'(reg_wr[i]), 256'(exp_wr));
        check({tag, "_reg"}, 256'(reg_o[i][32*ridx +: 32]), 256'(exp_reg));
        check({tag, "_dat_idle"}, 256'(dat_leak), 256'(0));
        idle_bus(i);
        @(posedge clk); #1;
        check({tag, "_ack_width"}, 256'({ack[i], dat_o[i], reg_wr[i]}), 256'(0));
    endtask

    // Out-of-window request held for 32 cycles: never acknowledged, no writes.
    task automatic miss(input int i, input logic [31:0] a, input logic [255:0] exp_regs,
                        input string tag);
        bit seen_ack = 1'b0;
        bit seen_wr = 1'b0;
        drive(i, 1'b1, a, 32'hFFFF_FFFF, 4'hF);
        for (int c = 0; c < 32; c++) begin
            @(posedge clk); #1;
            if (ack[i]) seen_ack = 1'b1;
            if (reg_wr[i] !== 8'h0) seen_wr = 1'b1;
        end
        idle_bus(i);
        check({tag, "_ack"}, 256'(seen_ack), 256'(0));
        check({tag, "_wr"}, 256'(seen_wr), 256'(0));
        check({tag, "_regs"}, reg_o[i], exp_regs);
    endtask

    initial begin
        logic [255:0] exp_u0;
        bit           abort_ack;
        bit           abort_wr;

        for (int i = 0; i < 4; i++) idle_bus(i);

        // Reset state.
        #12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_ack%0d", i), 256'(ack[i]), 256'(0));
            check($sformatf("rst_dat%0d", i), 256'(dat_o[i]), 256'(0));
            check($sformatf("rst_regs%0d", i), reg_o[i], 256'(0));
            check($sformatf("rst_wr%0d", i), 256'(reg_wr[i]), 256'(0));
            check($sformatf("rst_state%0d", i), 256'(dbg[i]), 256'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WAIT_CYCLES=1: full-word write then read of register 2.
        xfer(0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 8'b0000_0100, 2,
             32'hDEAD_BEEF, "w1_wr_reg2");
        xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 8'h00, 2,
             32'hDEAD_BEEF, "w1_rd_reg2");

        // Byte lanes on register 0.
        check("w1_reg0_init", 256'(reg_o[0][31:0]), 256'(0));
        xfer(0, 1'b1, BASE, 32'h1122_3344, 4'b0101, 2, 32'h0, 8'h01, 0,
             32'h0022_0044, "w1_sel0101");
        xfer(0, 1'b1, BASE, 32'hAABB_CCDD, 4'b0000, 2, 32'h0, 8'h01, 0,
             32'h0022_0044, "w1_sel0000");
        xfer(0, 1'b0, BASE, 32'h0, 4'b0001, 2, 32'h0022_0044, 8'h00, 0,
             32'h0022_0044, "w1_rd_reg0");

        // Misses: one past the window, misaligned, below base.
        exp_u0 = '0;
        exp_u0[31:0]  = 32'h0022_0044;
        exp_u0[95:64] = 32'hDEAD_BEEF;
        miss(0, BASE + 32'd32, exp_u0, "miss_top");
        miss(0, BASE + 32'd2, exp_u0, "miss_misalign");
        miss(0, BASE - 32'd4, exp_u0, "miss_below");

        // WAIT_CYCLES=0: ACK the cycle after the request; last register.
        xfer(1, 1'b1, BASE + 32'd28, 32'hCAFE_F00D, 4'hF, 1, 32'h0, 8'h80, 7,
             32'hCAFE_F00D, "w0_wr_reg7");
        xfer(1, 1'b0, BASE + 32'd28, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 8'h00, 7,
             32'hCAFE_F00D, "w0_rd_reg7");

        // WAIT_CYCLES=15: ACK sixteen cycles after the request.
        xfer(2, 1'b1, BASE + 32'd12, 32'h0BAD_F00D, 4'b1100, 16, 32'h0, 8'h08, 3,
             32'h0BAD_0000, "w15_wr_reg3");
        xfer(2, 1'b0, BASE + 32'd12, 32'h0, 4'hF, 16, 32'h0BAD_0000, 8'h00, 3,
             32'h0BAD_0000, "w15_rd_reg3");

        // WAIT_CYCLES=4: abort by dropping CYC_I after two cycles.
        drive(3, 1'b1, BASE, 32'h5, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        check("abort_in_wait", 256'(dbg[3]), 256'(1));
        cyc[3] = 1'b0;
        abort_ack = 1'b0;
        abort_wr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ack[3]) abort_ack = 1'b1;
            if (reg_wr[3] !== 8'h0) abort_wr = 1'b1;
        end
        idle_bus(3);
        check("abort_no_ack", 256'(abort_ack), 256'(0));
        check("abort_no_wr", 256'(abort_wr), 256'(0));
        check("abort_reg0", 256'(reg_o[3][31:0]), 256'(0));
        check("abort_state", 256'(dbg[3]), 256'(0));
        xfer(3, 1'b1, BASE + 32'd4, 32'h1234_5678, 4'hF, 5, 32'h0, 8'h02, 1,
             32'h1234_5678, "w4_after_abort");

        // Reset asserted while instance 3 sits in WAIT.
        drive(3, 1'b1, BASE, 32'hFFFF_FFFF, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        check("rst_mid_in_wait", 256'(dbg[3]), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 256'(ack[3]), 256'(0));
        check("rst_mid_dat", 256'(dat_o[3]), 256'(0));
        check("rst_mid_regs3", reg_o[3], 256'(0));
        check("rst_mid_regs0", reg_o[0], 256'(0));
        check("rst_mid_state", 256'(dbg[3]), 256'(0));
        idle_bus(3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(3, 1'b0, BASE, 32'h0, 4'hF, 5, 32'h0, 8'h00, 0, 32'h0, "w4_rd_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
